// File: rtl/mem_pkg.sv
// Shared types and address-classification helpers for the memory responder.
package mem_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Classification of a request address.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // Classify a byte address against a window of span_bytes starting at base.
  // The offset is a plain 32-bit unsigned difference. The below-base test runs
  // before the span test, so a wrapped offset is never used.
  function automatic logic [1:0] err_class(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span_bytes);
    logic [31:0] off;
    off = addr - base;
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if (addr < base) return ERR_RANGE;
    if ({1'b0, off} >= span_bytes) return ERR_RANGE;
    return ERR_NONE;
  endfunction

  // True when addr is word aligned and falls inside depth words starting at base.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int unsigned depth);
    return err_class(addr, base, 33'(depth) << 2) == ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array.
// It has a synchronous read and a byte-masked write. It has no reset so that it
// maps onto block RAM.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       wmask,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Enabled access: commit the enabled byte lanes and register the word at idx.
  // rdata holds its value while en is low.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder.
// It accepts one request at a time and waits LATENCY cycles. It then performs a
// word read or a byte-masked write and holds the response until the requester
// takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The requester holds req_* stable while req_valid is high and req_ready is
// low. Once resp_valid rises, resp_rdata and resp_err stay stable until the edge
// on which resp_ready is high.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  mem_state_t       state;
  logic [3:0]       cnt;
  logic [31:0]      addr_q;
  logic             wen_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;
  logic             rd_ok_q;

  logic [31:0]      acc_addr;
  logic             acc_wen;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_wmask;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             enter_resp;
  logic [31:0]      arr_rdata;

  assign req_ready = (state == IDLE);

  // Pick the source of the access. With LATENCY==1 the access happens on the
  // accept edge, before the capture registers hold the request, so the bus is
  // used directly. Otherwise the captured request is used.
  always_comb begin
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (state == IDLE) begin
      acc_addr  = req_addr;
      acc_wen   = req_wen;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
  end

  assign acc_err = !addr_ok(acc_addr, BASE_ADDR, DEPTH_WORDS);
  assign acc_idx = IDX_W'((acc_addr - BASE_ADDR) >> 2);

  // The access fires on the edge that moves the FSM into RESP.
  // Reset on that edge suppresses it, so a dropped write is never committed.
  assign enter_resp = !rst &&
                      (((state == IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == 4'd1)));

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (enter_resp && !acc_err),
    .we   (acc_wen),
    .wmask(acc_wmask),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // Read data comes straight from the array's output register. That register
  // only reloads on the next access, so it is stable through RESP. rd_ok_q
  // zeroes the data for writes, for errors and outside a response.
  assign resp_rdata = rd_ok_q ? arr_rdata : 32'd0;

  // Request FSM: capture, latency countdown, response hold and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_ok_q    <= 1'b0;
      addr_q     <= 32'd0;
      wen_q      <= 1'b0;
      wdata_q    <= 32'd0;
      wmask_q    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt     <= CNT_LOAD;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_ok_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        rd_ok_q    <= !acc_err && !acc_wen;
      end
    end
  end

  // Protocol properties: the two valid/ready sides never overlap, and a stalled
  // response holds still.
  a_no_overlap : assert property (@(posedge clk) disable iff (rst)
    !(req_ready && resp_valid));
  a_resp_hold : assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_err)));
  a_latency_range : assert property (@(posedge clk)
    (LATENCY >= 1) && (LATENCY <= 15));

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// Three instances run side by side, with LATENCY values of 2, 1 and 15.
module tb_mem_responder;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        req_wen    [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int checks;
  int errors;

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mem_responder #(
      .DEPTH_WORDS(4096),
      .BASE_ADDR  (32'h8000_0000),
      .LATENCY    (LAT)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .req_wen   (req_wen[g]),
      .req_wdata (req_wdata[g]),
      .req_wmask (req_wmask[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Driver: one request with resp_ready high.
  // It is called #1 after an edge while the instance is idle, and it returns
  // #1 after the handshake edge. lat is the number of edges from the accept
  // edge (counted as 1) to the first cycle with resp_valid high. It is capped
  // at 40 if no response arrives.
  task automatic xact(input int k, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask,
                      output logic [31:0] rdata, output logic err, output int lat);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lat = 1;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata[k];
    err   = resp_err[k];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_req_ready[%0d]: got %b want 1", k, req_ready[k]); end
      checks++;
      if (resp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d]: got %b want 0", k, resp_valid[k]); end
      checks++;
      if (resp_rdata[k] !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata[%0d]: got %h want 0", k, resp_rdata[k]); end
      checks++;
      if (resp_err[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_err[%0d]: got %b want 0", k, resp_err[k]); end
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lt;
    xact(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lt);
    checks++;
    if (lt !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lt); end
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL wr_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (lt !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lt); end
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr: got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic er; int lt;
    xact(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd, er, lt);
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL byte_mask: got %h want de22be44", rd); end
    // An empty mask is a legal write that changes nothing.
    xact(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, rd, er, lt);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL mask0_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (rd !== 32'hDE22_BE44) begin errors++; $display("FAIL mask0_data: got %h want de22be44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lt;
    // The two out-of-range writes would truncate onto word 0 and word 4095.
    xact(0, 1'b1, 32'h8000_0000, 32'hA5A5_0000, 4'hF, rd, er, lt);
    xact(0, 1'b1, 32'h8000_3FFC, 32'h5A5A_FFFF, 4'hF, rd, er, lt);
    xact(0, 1'b0, 32'h8000_0002, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misalign_rd: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    checks++;
    if (lt !== 2) begin errors++; $display("FAIL misalign_latency: got %0d want 2", lt); end
    xact(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, rd, er, lt);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL below_base_wr: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    xact(0, 1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rd, er, lt);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL above_top_wr: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    xact(0, 1'b0, 32'h8000_0000, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (er !== 1'b0 || rd !== 32'hA5A5_0000) begin errors++; $display("FAIL word0_unchanged: got err=%b rdata=%h want err=0 rdata=a5a50000", er, rd); end
    xact(0, 1'b0, 32'h8000_3FFC, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (er !== 1'b0 || rd !== 32'h5A5A_FFFF) begin errors++; $display("FAIL lastword_unchanged: got err=%b rdata=%h want err=0 rdata=5a5affff", er, rd); end
  endtask

  task automatic test_back_pressure();
    int n;
    resp_ready[0] = 1'b0;
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_before: got %b want 1", req_ready[0]); end
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_addr[0]  = 32'h8000_0010;
    @(posedge clk); #1;
    // A second read stays on the bus until the responder is idle again.
    req_addr[0] = 32'h8000_0000;
    n = 1;
    while (!resp_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, resp_valid[0]); end
      checks++;
      if (resp_rdata[0] !== 32'hDE22_BE44) begin errors++; $display("FAIL bp_rdata_hold[%0d]: got %h want de22be44", i, resp_rdata[0]); end
      checks++;
      if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready[0]); end
      @(posedge clk); #1;
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL bp_release: got req_ready=%b resp_valid=%b want 1 0", req_ready[0], resp_valid[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got req_ready=%b want 0", req_ready[0]); end
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (resp_rdata[0] !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_second_rdata: got %h want a5a50000", resp_rdata[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency(input int k);
    logic [31:0] rd; logic er; int lt;
    xact(k, 1'b1, 32'h8000_0040, 32'h0000_0100 + k, 4'hF, rd, er, lt);
    checks++;
    if (lt !== lat_of(k)) begin errors++; $display("FAIL lat_wr[%0d]: got %0d want %0d", k, lt, lat_of(k)); end
    xact(k, 1'b0, 32'h8000_0040, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (lt !== lat_of(k)) begin errors++; $display("FAIL lat_rd[%0d]: got %0d want %0d", k, lt, lat_of(k)); end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0000_0100 + k) begin
      errors++; $display("FAIL lat_data[%0d]: got err=%b rdata=%h want err=0 rdata=%h", k, er, rd, 32'h0000_0100 + k);
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [31:0] rd; logic er; int lt;
    logic [31:0] exp_q[$];
    int acc[$];
    int overlap;
    int budget;
    logic [31:0] a_val;
    logic [31:0] b_val;
    a_val = 32'hAAAA_0000 | k;
    b_val = 32'h5555_0000 | k;
    xact(k, 1'b1, 32'h8000_0050, a_val, 4'hF, rd, er, lt);
    xact(k, 1'b1, 32'h8000_0054, b_val, 4'hF, rd, er, lt);
    overlap = 0;
    budget = 3 * (lat_of(k) + 1) + lat_of(k) + 3;
    req_valid[k] = 1'b1;
    req_wen[k]   = 1'b0;
    req_addr[k]  = 32'h8000_0050;
    for (int c = 0; c < budget; c++) begin
      if (req_ready[k] && resp_valid[k]) overlap++;
      if (resp_valid[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_resp[%0d]: got rdata=%h want no response", k, resp_rdata[k]);
        end else if (resp_rdata[k] !== exp_q[0]) begin
          errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, resp_rdata[k], exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (req_ready[k] && req_valid[k]) begin
        exp_q.push_back((acc.size() % 2 == 1) ? b_val : a_val);
        acc.push_back(c);
      end
      @(posedge clk); #1;
      if (acc.size() >= 3) req_valid[k] = 1'b0;
      req_addr[k] = (acc.size() % 2 == 1) ? 32'h8000_0054 : 32'h8000_0050;
    end
    req_valid[k] = 1'b0;
    checks++;
    if (acc.size() !== 3) begin
      errors++; $display("FAIL b2b_accepts[%0d]: got %0d want 3", k, acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] !== lat_of(k) + 1 || acc[2] - acc[1] !== lat_of(k) + 1) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got %0d,%0d want %0d", k, acc[1] - acc[0], acc[2] - acc[1], lat_of(k) + 1);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_missing_resp[%0d]: got %0d pending want 0", k, exp_q.size()); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap[%0d]: got %0d cycles want 0", k, overlap); end
  endtask

  task automatic test_reset_mid_wait(input int k, input int wait_cycles);
    logic [31:0] rd; logic er; int lt;
    xact(k, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, rd, er, lt);
    req_valid[k] = 1'b1;
    req_wen[k]   = 1'b1;
    req_addr[k]  = 32'h8000_0020;
    req_wdata[k] = 32'hFFFF_FFFF;
    req_wmask[k] = 4'hF;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    repeat (wait_cycles) begin @(posedge clk); #1; end
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    checks++;
    if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0) begin
      errors++; $display("FAIL rst_wait_state[%0d]: got req_ready=%b resp_valid=%b want 1 0", k, req_ready[k], resp_valid[k]);
    end
    xact(k, 1'b0, 32'h8000_0020, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rst_wait_data[%0d]: got err=%b rdata=%h want err=0 rdata=0badf00d", k, er, rd);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] rd; logic er; int lt; int n;
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h8000_0030;
    req_wdata[0] = 32'h1234_5678;
    req_wmask[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 40) begin @(posedge clk); #1; n++; end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    resp_ready[0] = 1'b1;
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rst_resp_state: got resp_valid=%b req_ready=%b want 0 1", resp_valid[0], req_ready[0]);
    end
    xact(0, 1'b0, 32'h8000_0030, 32'd0, 4'h0, rd, er, lt);
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rst_resp_kept: got %h want 12345678", rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k]        = 1'b1;
      req_valid[k]  = 1'b0;
      req_addr[k]   = 32'd0;
      req_wen[k]    = 1'b0;
      req_wdata[k]  = 32'd0;
      req_wmask[k]  = 4'd0;
      resp_ready[k] = 1'b1;
    end
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_back_pressure();
    for (int k = 0; k < 3; k++) test_latency(k);
    for (int k = 0; k < 3; k++) test_back_to_back(k);
    test_reset_mid_wait(0, 0);
    test_reset_mid_wait(2, 3);
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's fetch/load-store port: the target end of the request/response handshake that the core drives with a PC or data address. It accepts one request at a time, waits a programmable number of cycles, performs a word read or byte-masked write on an internal word array, and returns a response under back-pressure. It replaces the zero-latency combinational instruction memory when the core moves to a handshaked bus, and exercises the core's stall paths.

## Interface
Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array (power of two)
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_wmask  in  4  byte-lane write enables; bit i covers bits 8i+7:8i
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  32  read data; 0 for writes and errors
- resp_err  out  1  address out of range or misaligned

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: capture addr, wen, wdata, wmask; load cnt = LATENCY-1. If LATENCY==1, go straight to RESP; otherwise go to WAIT.
- WAIT: req_ready=0; cnt decrements each cycle; when cnt==1, go to RESP on the next edge.
- Access happens on the edge that enters RESP:
  - the read is captured into resp_rdata;
  - the write is committed to the enabled byte lanes.
- Error check on the captured address:
  - err = (addr[1:0] != 0) OR (addr < BASE_ADDR) OR (addr - BASE_ADDR >= DEPTH_WORDS*4).
  - On err: no array write, resp_rdata=0, resp_err=1.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits. The subtraction is 32-bit unsigned, and the range check precedes indexing.
- Writes return resp_rdata=0. wmask=4'b0000 is a legal no-op write with err=0.
- RESP: resp_valid=1, and resp_rdata/resp_err are held stable until the handshake. On resp_valid & resp_ready, return to IDLE.
- There is no IDLE-bypass from RESP, so throughput is at most one request per LATENCY+1 cycles.
- Reset:
  - Reset values: state=IDLE, req_ready=1 (combinational from state), resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
  - Array contents are not cleared.
  - Reset in WAIT drops the pending request; a pending write is not committed.
  - Reset in RESP drops the response; a write already committed stays.
- A request presented while req_ready=0 is ignored; the requester must hold it.

## Timing
- Accept on cycle T (req_valid & req_ready at edge T). resp_valid asserts from cycle T+LATENCY.
- Earliest next acceptance is edge T+LATENCY+1, when resp_ready=1 at edge T+LATENCY.
- req_ready and resp_valid are never both 1.
- All outputs are registered except req_ready, which decodes from state.
- A read after a write to the same word returns the new data. This holds naturally, because the write commits before the next acceptance.
- Memory read is synchronous (registered array output), so the array maps to block RAM.

## Structure
- Shared package mem_pkg holds:
  - enum mem_state_t {IDLE, WAIT, RESP};
  - localparams for ERR_MISALIGN/ERR_RANGE classification;
  - function addr_ok(addr, base, depth).
- Sub-module mem_array:
  - DEPTH_WORDS x 32, synchronous read, byte-masked write, single port.
  - Ports: clk, en, we, wmask, idx, wdata, rdata.
  - No reset.
- The top holds the FSM, the latency counter and the capture registers.

## Test plan
- Write, then read, LATENCY=2: write addr 0x8000_0010, data 0xDEAD_BEEF, mask 4'hF.
  - Response at T+2 with err=0, rdata=0.
  - A read of the same address then returns 0xDEAD_BEEF with err=0.
- Byte mask: write 0x1122_3344 with mask 4'b0101 over 0xDEAD_BEEF; a read returns 0xDE22_BE44.
- Errors:
  - A read of 0x8000_0002 returns err=1, rdata=0.
  - A write to 0x7FFF_FFFC and a write to BASE+DEPTH_WORDS*4 each return err=1, and a later read shows the array unchanged.
- Back-pressure: hold resp_ready=0 for 5 cycles.
  - resp_valid and resp_rdata stay stable and req_ready stays 0.
  - A second req_valid is not accepted until the cycle after resp_ready=1.
- LATENCY=1 and LATENCY=15 sweeps: resp_valid rises exactly at T+1 and at T+15. Back-to-back reads with resp_ready=1 are accepted every LATENCY+1 cycles.
- Reset mid-WAIT: assert rst during WAIT of a write to 0x8000_0020.
  - Next cycle: req_ready=1, resp_valid=0.
  - A subsequent read of 0x8000_0020 returns the old data.
